// File: rtl/alu_share_arb.sv
// Round-robin arbiter that lends one shared combinational ALU to two clients.
// One operation is in flight at a time: IDLE -> EXEC -> RESP -> IDLE.
module alu_share_arb #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [2:0]   req0_opc,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [W-1:0] rsp0_w,
    output logic         rsp0_zero,
    output logic         rsp0_err,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [2:0]   req1_opc,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W-1:0] rsp1_w,
    output logic         rsp1_zero,
    output logic         rsp1_err,

    output logic [2:0]   alu_opc,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_w,
    input  logic         alu_zero,

    output logic         busy,
    output logic [1:0]   dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; a requester keeps valid and its fields stable until then, and
    // the arbiter keeps rsp fields stable while rsp_valid is high.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OPC_ILLEGAL = 3'b111;

    state_t         state_q;
    logic           prio_q;
    logic           owner_q;
    logic [2:0]     opc_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   res_w_q;
    logic           res_zero_q;
    logic           res_err_q;

    logic           is_idle;
    logic           grant1;
    logic           fire0;
    logic           fire1;
    logic           owner_rsp_ready;

    // With both valid the favoured client wins; otherwise whoever is asking.
    assign is_idle    = (state_q == IDLE);
    assign grant1     = (req0_valid && req1_valid) ? prio_q : req1_valid;
    assign req0_ready = is_idle && req0_valid && !grant1;
    assign req1_ready = is_idle && req1_valid && grant1;
    assign fire0      = req0_valid && req0_ready;
    assign fire1      = req1_valid && req1_ready;

    assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            owner_q    <= 1'b0;
            opc_q      <= 3'b000;
            a_q        <= '0;
            b_q        <= '0;
            res_w_q    <= '0;
            res_zero_q <= 1'b0;
            res_err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fire0 || fire1) begin
                        opc_q   <= fire1 ? req1_opc : req0_opc;
                        a_q     <= fire1 ? req1_a : req0_a;
                        b_q     <= fire1 ? req1_b : req0_b;
                        owner_q <= fire1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    // An illegal opcode never trusts whatever the ALU produced.
                    if (opc_q == OPC_ILLEGAL) begin
                        res_w_q    <= '0;
                        res_zero_q <= 1'b1;
                        res_err_q  <= 1'b1;
                    end else begin
                        res_w_q    <= alu_w;
                        res_zero_q <= alu_zero;
                        res_err_q  <= 1'b0;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    if (owner_rsp_ready) begin
                        prio_q  <= ~owner_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp0_valid = (state_q == RESP) && !owner_q;
    assign rsp1_valid = (state_q == RESP) && owner_q;
    assign rsp0_w     = res_w_q;
    assign rsp0_zero  = res_zero_q;
    assign rsp0_err   = res_err_q;
    assign rsp1_w     = res_w_q;
    assign rsp1_zero  = res_zero_q;
    assign rsp1_err   = res_err_q;

    // The ALU sees a quiet all-zero ADD except while the granted op executes.
    assign alu_opc = (state_q == EXEC) ? opc_q : 3'b000;
    assign alu_a   = (state_q == EXEC) ? a_q : '0;
    assign alu_b   = (state_q == EXEC) ? b_q : '0;

    assign busy        = !is_idle;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: transaction-level model of the arbiter plus a
// stand-in ALU, compared against the DUT every cycle, with directed scenarios.
module tb_alu_share_arb;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         rv [2];
    logic [2:0]   ro [2];
    logic [W-1:0] ra [2];
    logic [W-1:0] rb [2];
    logic         sr [2];
    logic         force_low [2];
    logic         rand_rsp;

    logic [1:0]   req_rdy;
    logic         rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
    logic [W-1:0] rsp0_w, rsp1_w;
    logic [2:0]   alu_opc;
    logic [W-1:0] alu_a, alu_b, alu_w_e;
    logic         alu_zero_e;
    logic         busy;
    logic [1:0]   dbg_state;

    int tests = 0;
    int failed = 0;

    alu_share_arb #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (rv[0]),
        .req0_ready (req_rdy[0]),
        .req0_opc   (ro[0]),
        .req0_a     (ra[0]),
        .req0_b     (rb[0]),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (sr[0]),
        .rsp0_w     (rsp0_w),
        .rsp0_zero  (rsp0_zero),
        .rsp0_err   (rsp0_err),
        .req1_valid (rv[1]),
        .req1_ready (req_rdy[1]),
        .req1_opc   (ro[1]),
        .req1_a     (ra[1]),
        .req1_b     (rb[1]),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (sr[1]),
        .rsp1_w     (rsp1_w),
        .rsp1_zero  (rsp1_zero),
        .rsp1_err   (rsp1_err),
        .alu_opc    (alu_opc),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_w      (alu_w_e),
        .alu_zero   (alu_zero_e),
        .busy       (busy),
        .dbg_state_o(dbg_state)
    );

    // Reference result as {err, zero, w}.
    function automatic logic [W+1:0] ref_op(input logic [2:0] o, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [W-1:0] r;
        r = '0;
        case (o)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            3'd6: r = {{(W-1){1'b0}}, (a < b)};
            default: return {1'b1, 1'b1, {W{1'b0}}};
        endcase
        return {1'b0, (r == '0), r};
    endfunction

    // Stand-in ALU; returns junk on the illegal opcode so it must be ignored.
    logic [W+1:0] env_r;
    always_comb begin
        env_r      = ref_op(alu_opc, alu_a, alu_b);
        alu_w_e    = env_r[W-1:0];
        alu_zero_e = env_r[W];
        if (alu_opc == 3'b111) begin
            alu_w_e    = 32'hDEAD_BEEF;
            alu_zero_e = 1'b0;
        end
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: one op in flight, result known at acceptance,
    // response offered from the cycle after the execute cycle.
    bit           m_busy = 1'b0;
    int           m_age = 0;
    int           m_owner = 0;
    int           m_prio = 0;
    logic [2:0]   m_opc = 3'b000;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic [W+1:0] exp_q0 [$];
    logic [W+1:0] exp_q1 [$];
    int           grant_log [$];
    logic [W+2:0] rsp_log [$];

    initial begin
        int g;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 1'b0; m_age = 0; m_owner = 0; m_prio = 0;
                m_opc = 3'b000; m_a = '0; m_b = '0;
                exp_q0.delete(); exp_q1.delete();
            end else if (!m_busy) begin
                g = -1;
                if (rv[0] && rv[1]) g = m_prio;
                else if (rv[0])     g = 0;
                else if (rv[1])     g = 1;
                if (g >= 0) begin
                    m_busy = 1'b1; m_age = 0; m_owner = g;
                    m_opc = ro[g]; m_a = ra[g]; m_b = rb[g];
                    if (g == 0) exp_q0.push_back(ref_op(ro[g], ra[g], rb[g]));
                    else        exp_q1.push_back(ref_op(ro[g], ra[g], rb[g]));
                    grant_log.push_back(g);
                end
            end else if (m_age == 0) begin
                m_age = 1;
            end else if (sr[m_owner]) begin
                if (m_owner == 0 && exp_q0.size() > 0) begin
                    rsp_log.push_back({1'b0, exp_q0[0]});
                    void'(exp_q0.pop_front());
                end else if (m_owner == 1 && exp_q1.size() > 0) begin
                    rsp_log.push_back({1'b1, exp_q1[0]});
                    void'(exp_q1.pop_front());
                end
                m_busy = 1'b0;
                m_prio = 1 - m_owner;
            end
        end
    end

    // Per-cycle compare of every output against the model.
    initial begin
        logic e_rdy0, e_rdy1, e_v0, e_v1, e_exec;
        forever begin
            @(negedge clk);
            e_rdy0 = !m_busy && rv[0] && (!rv[1] || m_prio == 0);
            e_rdy1 = !m_busy && rv[1] && (!rv[0] || m_prio == 1);
            e_v0   = m_busy && m_age == 1 && m_owner == 0;
            e_v1   = m_busy && m_age == 1 && m_owner == 1;
            e_exec = m_busy && m_age == 0;
            chk("req0_ready", 64'(req_rdy[0]), 64'(e_rdy0));
            chk("req1_ready", 64'(req_rdy[1]), 64'(e_rdy1));
            chk("rsp0_valid", 64'(rsp0_valid), 64'(e_v0));
            chk("rsp1_valid", 64'(rsp1_valid), 64'(e_v1));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("alu_opc", 64'(alu_opc), e_exec ? 64'(m_opc) : 64'd0);
            chk("alu_a", 64'(alu_a), e_exec ? 64'(m_a) : 64'd0);
            chk("alu_b", 64'(alu_b), e_exec ? 64'(m_b) : 64'd0);
            if (e_v0) begin
                if (exp_q0.size() == 0) chk("rsp0_unexpected", 64'(rsp0_valid), 64'd0);
                else chk("rsp0_data", 64'({rsp0_err, rsp0_zero, rsp0_w}), 64'(exp_q0[0]));
            end
            if (e_v1) begin
                if (exp_q1.size() == 0) chk("rsp1_unexpected", 64'(rsp1_valid), 64'd0);
                else chk("rsp1_data", 64'({rsp1_err, rsp1_zero, rsp1_w}), 64'(exp_q1[0]));
            end
        end
    end

    // Response-ready driver, updated away from both the edge and the compare.
    initial begin
        sr[0] = 1'b0;
        sr[1] = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < 2; i++)
                sr[i] = force_low[i] ? 1'b0 : (rand_rsp ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int c, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b);
        int n;
        logic r;
        rv[c] = 1'b1; ro[c] = o; ra[c] = a; rb[c] = b;
        n = 0; r = 1'b0;
        while (!r && n < 300) begin
            @(negedge clk);
            r = req_rdy[c];
            sync();
            n++;
        end
        if (!r) begin
            tests++; failed++;
            $display("FAIL send_timeout: client %0d actual=no grant required=grant within 300 cycles", c);
        end
        rv[c] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || m_busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy || m_busy) begin
            tests++; failed++;
            $display("FAIL idle_timeout: actual=busy required=idle within 100 cycles");
        end
        sync();
    endtask

    task automatic expect_rsp0(input string name, input logic [W-1:0] w, input logic z,
                               input logic e);
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp0_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_valid"}, 64'(rsp0_valid), 64'd1);
        chk({name, "_w"}, 64'(rsp0_w), 64'(w));
        chk({name, "_zero"}, 64'(rsp0_zero), 64'(z));
        chk({name, "_err"}, 64'(rsp0_err), 64'(e));
        sync();
    endtask

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 3))
            0: return W'($urandom_range(0, 3));
            1: return {W{1'b1}};
            default: return W'($urandom());
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; ro[i] = 3'b000; ra[i] = '0; rb[i] = '0; force_low[i] = 1'b0;
        end
        rand_rsp = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset values, then async reset in the middle of an execute cycle.
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_alu_opc", 64'(alu_opc), 64'd0);
        chk("rst_rsp_valid", 64'({rsp0_valid, rsp1_valid}), 64'd0);
        sync();
        send(0, 3'd0, 32'd1, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rsp0_valid", 64'(rsp0_valid), 64'd0);
        chk("arst_rsp1_valid", 64'(rsp1_valid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_alu_opc", 64'(alu_opc), 64'd0);
        sync();
        rst_n = 1'b1;

        // Fairness: both continuously valid, first dual grant goes to client 0.
        grant_log.delete();
        rsp_log.delete();
        fork
            begin
                send(0, 3'd1, 32'd10, 32'd3);
                send(0, 3'd1, 32'd10, 32'd3);
            end
            begin
                send(1, 3'd5, 32'hFFFF_FFFF, 32'd1);
                send(1, 3'd5, 32'hFFFF_FFFF, 32'd1);
            end
        join
        wait_idle();
        chk("fair_count", 64'(grant_log.size()), 64'd4);
        chk("fair_rsp_count", 64'(rsp_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < grant_log.size() && i < rsp_log.size(); i++) begin
            chk("fair_grant", 64'(grant_log[i]), 64'(i % 2));
            chk("fair_rsp_owner", 64'(rsp_log[i][W+2]), 64'(i % 2));
            chk("fair_rsp_w", 64'(rsp_log[i][W-1:0]), (i % 2 == 0) ? 64'd7 : 64'd1);
            chk("fair_rsp_zero_err", 64'(rsp_log[i][W+1:W]), 64'd0);
        end

        // Single op with exact latency: response in the cycle after execute.
        send(0, 3'd0, 32'h0000_0005, 32'hFFFF_FFFB);
        @(negedge clk);
        chk("single_exec_valid", 64'(rsp0_valid), 64'd0);
        @(negedge clk);
        chk("single_valid", 64'(rsp0_valid), 64'd1);
        chk("single_w", 64'(rsp0_w), 64'd0);
        chk("single_zero", 64'(rsp0_zero), 64'd1);
        chk("single_err", 64'(rsp0_err), 64'd0);
        chk("single_rsp1_valid", 64'(rsp1_valid), 64'd0);
        sync();
        wait_idle();

        // Backpressure on client 1 while client 0 waits.
        force_low[1] = 1'b1;
        send(1, 3'd6, 32'hFFFF_FFFF, 32'd1);
        fork
            send(0, 3'd0, 32'h11, 32'h22);
            begin
                @(negedge clk);
                chk("bp_exec_req0_ready", 64'(req_rdy[0]), 64'd0);
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_rsp1_valid", 64'(rsp1_valid), 64'd1);
                    chk("bp_rsp1_w", 64'(rsp1_w), 64'd0);
                    chk("bp_rsp1_zero", 64'(rsp1_zero), 64'd1);
                    chk("bp_req0_ready", 64'(req_rdy[0]), 64'd0);
                    chk("bp_busy", 64'(busy), 64'd1);
                end
                sync();
                force_low[1] = 1'b0;
            end
        join
        wait_idle();

        // Illegal opcode followed by a legal XOR.
        send(0, 3'd7, 32'h1234, 32'h1234);
        expect_rsp0("illegal", 32'd0, 1'b1, 1'b1);
        send(0, 3'd4, 32'hF0F0, 32'h0F0F);
        expect_rsp0("xor", 32'h0000_FFFF, 1'b0, 1'b0);
        wait_idle();

        // Client 1 arrives while client 0 is being served.
        fork
            send(0, 3'd0, 32'd3, 32'd4);
            begin
                sync();
                send(1, 3'd3, 32'hA5, 32'h5A);
            end
        join
        wait_idle();

        // Randomized traffic from both clients with random response stalls.
        rand_rsp = 1'b1;
        fork
            for (int k = 0; k < 50; k++) begin
                repeat ($urandom_range(0, 3)) sync();
                send(0, 3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd());
            end
            for (int k = 0; k < 50; k++) begin
                repeat ($urandom_range(0, 3)) sync();
                send(1, 3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd());
            end
        join
        rand_rsp = 1'b0;
        wait_idle();
        chk("drain_q0", 64'(exp_q0.size()), 64'd0);
        chk("drain_q1", 64'(exp_q1.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=still running required=finished before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
